// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the pipeline memory stage.
// Holds the LSU state encoding, the RV32I load/store funct3 codes and the
// small pure helpers used to decode legality, byte enables and store lanes.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // True when the funct3 is defined for the direction and the address is naturally aligned
    function automatic logic access_legal(input logic write, input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic legal;
        legal = 1'b0;
        if (write) begin
            if (funct3 == F3_SB)      legal = 1'b1;
            else if (funct3 == F3_SH) legal = ~offset[0];
            else if (funct3 == F3_SW) legal = (offset == 2'b00);
        end else begin
            if (funct3 == F3_LB || funct3 == F3_LBU)      legal = 1'b1;
            else if (funct3 == F3_LH || funct3 == F3_LHU) legal = ~offset[0];
            else if (funct3 == F3_LW)                     legal = (offset == 2'b00);
        end
        return legal;
    endfunction

    // Byte enables for the word-aligned bus; loads always fetch the full word
    function automatic logic [3:0] lane_be(input logic write, input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic [3:0] be;
        be = 4'b1111;
        if (write && funct3 == F3_SB)      be = 4'b0001 << offset;
        else if (write && funct3 == F3_SH) be = 4'b0011 << offset;
        return be;
    endfunction

    // Store data replicated across lanes so the byte enables pick the right copy
    function automatic logic [31:0] lane_wdata(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] data;
        data = wdata;
        if (funct3 == F3_SB)      data = {4{wdata[7:0]}};
        else if (funct3 == F3_SH) data = {2{wdata[15:0]}};
        return data;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/halfword out of a 32-bit read
// word and sign- or zero-extends it according to the load funct3.
module lsu_load_align
    import pipeline_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension
    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit for an RV32I pipeline.
// Captures a legal memory instruction from EX/MEM, runs one transfer on the
// data-memory bus and stalls the pipeline until the result is available.
// Optional: define LSU_TIMEOUT_EN to add a bus-wait timeout of TIMEOUT_CYCLES
// cycles that aborts the transfer with bus_err.
//
// Bus handshake: dmem_req is a valid signal held high, with dmem_we/addr/be/
// wdata stable, until the cycle dmem_gnt (ready) is high; that cycle is the
// transfer. Load data may return with dmem_rvalid in the grant cycle or any
// later cycle; dmem_rvalid is ignored unless a transfer is outstanding.
module mem_lsu
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        access_err,
    output logic        bus_err,
    output lsu_state_t  fsm_state
);

    lsu_state_t  state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data_q;
    logic [31:0] aligned;
    logic        req_legal;
    logic        accept;
    logic        reject;
    logic        busy;
    logic        complete;
    logic        timed_out;

    lsu_load_align u_align (
        .rdata  (dmem_rdata),
        .funct3 (funct3_q),
        .offset (offset_q),
        .data   (aligned)
    );

    // Request decode and transfer-completion detection
    always_comb begin
        req_legal = access_legal(req_write, req_funct3, req_addr[1:0]);
        accept    = (state == IDLE) && req_valid && req_legal && !reset;
        reject    = (state == IDLE) && req_valid && !req_legal && !reset;
        busy      = (state == REQ) || (state == WAIT);
        complete  = ((state == REQ) && dmem_gnt && (we_q || dmem_rvalid)) ||
                    ((state == WAIT) && dmem_rvalid);
    end

    assign stall      = accept || busy;
    assign access_err = reject;
    assign dmem_req   = (state == REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign load_data  = (state == DONE) ? load_data_q : 32'h0;
    assign fsm_state  = state;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timed_out = busy && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_err   = err_q;

    // Count cycles spent on the bus; flag a timeout for the single DONE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= busy ? (wait_cnt + CNT_W'(1)) : '0;
            err_q    <= timed_out && !complete;
        end
    end
`else
    assign timed_out = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Transfer sequencer: capture, request, wait for data, one-cycle result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            addr_q      <= 32'h0;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0;
            load_data_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q     <= req_write;
                        funct3_q <= req_funct3;
                        offset_q <= req_addr[1:0];
                        addr_q   <= {req_addr[31:2], 2'b00};
                        be_q     <= lane_be(req_write, req_funct3, req_addr[1:0]);
                        wdata_q  <= req_write ? lane_wdata(req_funct3, req_wdata) : 32'h0;
                        state    <= REQ;
                    end
                end
                REQ, WAIT: begin
                    if (complete) begin
                        if (!we_q) load_data_q <= aligned;
                        state <= DONE;
                    end else if (timed_out) begin
                        state <= DONE;
                    end else if (state == REQ && dmem_gnt) begin
                        state <= WAIT;
                    end
                end
                default: begin
                    load_data_q <= 32'h0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
